// File: rtl/ysyx_23060332_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids,
// and the memory bus widths used across the core.
package ysyx_23060332_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = 8;

    localparam logic [MEM_DATA_W-1:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/ysyx_23060332_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to whoever
// was not granted last. Purely combinational; history lives in the parent.
module ysyx_23060332_rr_arb2
    import ysyx_23060332_mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last_grant == OWN_LSU) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Shares one memory port between IFU (read) and LSU (read/write): accept one
// request, wait LAT cycles, strobe memory once, then hold the response.
module ysyx_23060332_mem_arbiter
    import ysyx_23060332_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_arvalid,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    output logic                  ifu_arready,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  ifu_rready,
    input  logic                  lsu_valid,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [MEM_MASK_W-1:0] lsu_wmask,
    output logic                  lsu_ready,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    input  logic                  lsu_resp_ready,
    output logic                  mem_ren,
    output logic [ADDR_W-1:0]     mem_raddr,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [MEM_MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LAT);
    localparam bit               LAT_ZERO = (LAT == 0);

    logic [1:0]            r_state;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_wen;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [MEM_MASK_W-1:0] r_wmask;
    logic [DATA_W-1:0]     r_rdata;

    logic [1:0] w_grant;
    logic       w_idle;
    logic       w_ifu_acc;
    logic       w_lsu_acc;
    logic       w_resp;
    logic       w_access;
    logic       w_resp_done;

    ysyx_23060332_rr_arb2 u_rr_arb2 (
        .i_req        ({lsu_valid, ifu_arvalid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Readies are gated by rst so every output reads 0 while reset is held.
    assign w_idle      = (r_state == ST_IDLE) & ~rst;
    assign w_access    = (r_state == ST_ACCESS);
    assign w_resp      = (r_state == ST_RESP);
    assign ifu_arready = w_idle & w_grant[0];
    assign lsu_ready   = w_idle & w_grant[1];
    assign w_ifu_acc   = ifu_arvalid & ifu_arready;
    assign w_lsu_acc   = lsu_valid & lsu_ready;
    assign w_resp_done = w_resp & ((r_owner == OWN_IFU) ? ifu_rready : lsu_resp_ready);

    assign ifu_rvalid     = w_resp & (r_owner == OWN_IFU);
    assign lsu_resp_valid = w_resp & (r_owner == OWN_LSU);
    assign ifu_rdata      = (r_owner == OWN_IFU) ? r_rdata : '0;
    assign lsu_rdata      = (r_owner == OWN_LSU) ? r_rdata : '0;

    assign mem_ren   = w_access & ~r_wen;
    assign mem_wen   = w_access & r_wen;
    assign mem_raddr = r_addr;
    assign mem_waddr = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_LSU;
            r_wen        <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ifu_acc || w_lsu_acc) begin
                        r_owner      <= w_lsu_acc ? OWN_LSU : OWN_IFU;
                        r_last_grant <= w_lsu_acc ? OWN_LSU : OWN_IFU;
                        r_wen        <= w_lsu_acc & lsu_wen;
                        r_addr       <= w_lsu_acc ? lsu_addr : ifu_araddr;
                        r_wdata      <= w_lsu_acc ? lsu_wdata : '0;
                        r_wmask      <= w_lsu_acc ? lsu_wmask : '0;
                        r_cnt        <= LAT_CNT;
                        r_state      <= LAT_ZERO ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Stores answer with a zero word so the LSU never sees stale load data.
                    r_rdata <= r_wen ? DATA_W'(ZeroWord) : mem_rdata;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_resp_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
